// File: rtl/idex_skid_buffer.sv
// idex_skid_buffer: ID/EX stage register with valid/ready handshake, optional 2-entry skid, flush, bubble zeroing and stall counter
module idex_skid_buffer #(
  parameter int CTRL_W = 10,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_dr1,
  input  logic [DATA_W-1:0] in_dr2,
  input  logic [DATA_W-1:0] in_signe,
  input  logic [REG_W-1:0]  in_ins1,
  input  logic [REG_W-1:0]  in_ins2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_dr1,
  output logic [DATA_W-1:0] out_dr2,
  output logic [DATA_W-1:0] out_signe,
  output logic [REG_W-1:0]  out_ins1,
  output logic [REG_W-1:0]  out_ins2,
  output logic [CNT_W-1:0]  stall_cnt
);
  localparam int W = CTRL_W + 3 * DATA_W + 2 * REG_W;
  logic [W-1:0]      in_word, main_q, skid_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic              skid_v, in_xfer, out_xfer;
  assign in_word  = {in_ctrl, in_dr1, in_dr2, in_signe, in_ins1, in_ins2};
  assign {ctrl_q, out_dr1, out_dr2, out_signe, out_ins1, out_ins2} = main_q;
  // control is gated so an empty slot always presents a bubble to EX
  assign out_ctrl = out_valid ? ctrl_q : '0;
  assign in_ready = (SKID != 0) ? !skid_v : (!out_valid || out_ready);
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      main_q    <= '0;
      skid_v    <= 1'b0;
      skid_q    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      skid_v    <= 1'b0;
    end else if (!out_valid || out_xfer) begin
      if (skid_v) begin
        main_q    <= skid_q;
        out_valid <= 1'b1;
        skid_v    <= 1'b0;
      end else begin
        out_valid <= in_xfer;
        if (in_xfer) main_q <= in_word;
      end
    end else if (SKID != 0 && in_xfer) begin
      skid_q <= in_word;
      skid_v <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) stall_cnt <= '0;
    else if (out_valid && !out_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
  end
endmodule
